// File: rtl/btn_pkg.sv
// Shared defaults and helpers for the multi-channel button debouncer.
package btn_pkg;

  localparam int unsigned DEF_N_CH        = 4;
  localparam int unsigned DEF_CNT_W       = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_LONG_CYCLES = 1000;

  // Bits needed to hold values 0..value-1, i.e. ceil(log2(value)).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// Single button channel: synchroniser, saturating integrator with hysteresis,
// registered edge pulses and a one-shot long-press detector.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_out,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_long
);

  localparam int unsigned      HOLD_W   = clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   set_lvl;
  logic                   clr_lvl;
  logic                   out_d;
  logic [HOLD_W-1:0]      hold_q;
  logic [HOLD_W-1:0]      hold_d;
  logic                   long_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  always_comb begin
    s       = sync_q[SYNC_STAGES-1];
    cnt_d   = cnt_q;
    if (s && (cnt_q != CNT_MAX))       cnt_d = cnt_q + CNT_W'(1);
    else if (!s && (cnt_q != '0))      cnt_d = cnt_q - CNT_W'(1);
    set_lvl = s && (cnt_q == CNT_MAX);
    clr_lvl = !s && (cnt_q == '0);
    out_d   = btn_out;
    if (set_lvl)      out_d = 1'b1;
    else if (clr_lvl) out_d = 1'b0;
  end

  // Hold counter follows the registered level, so it starts one cycle after
  // btn_rise; a long pulse is suppressed if the level drops on the same edge.
  always_comb begin
    hold_d = hold_q;
    if (!btn_out)                hold_d = '0;
    else if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
    long_d = btn_out && (hold_q == HOLD_PRE) && !clr_lvl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      hold_q   <= '0;
      btn_out  <= 1'b0;
      btn_rise <= 1'b0;
      btn_fall <= 1'b0;
      btn_long <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      btn_out  <= out_d;
      btn_rise <= out_d & ~btn_out;
      btn_fall <= ~out_d & btn_out;
      btn_long <= long_d;
    end
  end

endmodule

// File: rtl/btn_debounce_multi.sv
// N_CH independent debounced button channels sharing one clock and reset.
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int unsigned N_CH        = DEF_N_CH,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_out,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_long
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .LONG_CYCLES (LONG_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_in   (btn_in[i]),
      .btn_out  (btn_out[i]),
      .btn_rise (btn_rise[i]),
      .btn_fall (btn_fall[i]),
      .btn_long (btn_long[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Self-checking bench for btn_debounce_multi with a behavioural reference model.
module tb_btn_debounce_multi;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned LONG  = 50;
  localparam int          MAXC  = (1 << CNT_W) - 1;
  localparam int          LAT   = SYNC + MAXC + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_CH-1:0] btn_in = '0;
  logic [N_CH-1:0] btn_out, btn_rise, btn_fall, btn_long;

  always #5 clk = ~clk;

  btn_debounce_multi #(
    .N_CH        (N_CH),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC),
    .LONG_CYCLES (LONG)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_in   (btn_in),
    .btn_out  (btn_out),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall),
    .btn_long (btn_long)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: delay line of input samples, integer integrators,
  // hysteresis level and a press-duration counter per channel.
  logic [N_CH-1:0] m_hist [SYNC];
  int              m_cnt  [N_CH];
  int              m_hold [N_CH];
  logic [N_CH-1:0] m_out, m_rise, m_fall, m_long;

  task automatic model_reset();
    for (int i = 0; i < int'(SYNC); i++) m_hist[i] = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      m_cnt[c]  = 0;
      m_hold[c] = 0;
    end
    m_out = '0; m_rise = '0; m_fall = '0; m_long = '0;
  endtask

  task automatic model_step();
    logic [N_CH-1:0] s_vec;
    logic            s, old_out, new_out;
    int              old_cnt, old_hold;
    s_vec = m_hist[SYNC-1];
    for (int i = int'(SYNC) - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = btn_in;
    for (int c = 0; c < int'(N_CH); c++) begin
      s        = s_vec[c];
      old_out  = m_out[c];
      old_cnt  = m_cnt[c];
      old_hold = m_hold[c];
      if (s && old_cnt == MAXC)   new_out = 1'b1;
      else if (!s && old_cnt == 0) new_out = 1'b0;
      else                         new_out = old_out;
      m_cnt[c]  = s ? ((old_cnt + 1 > MAXC) ? MAXC : old_cnt + 1)
                    : ((old_cnt - 1 < 0) ? 0 : old_cnt - 1);
      m_hold[c] = old_out ? ((old_hold + 1 > int'(LONG)) ? int'(LONG) : old_hold + 1) : 0;
      m_rise[c] = new_out && !old_out;
      m_fall[c] = !new_out && old_out;
      m_long[c] = old_out && new_out && (old_hold == int'(LONG) - 1);
      m_out[c]  = new_out;
    end
  endtask

  // Advance one clock edge; returns 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    btn_in = '0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    total++; if (btn_out  !== '0) begin bad++; $display("FAIL reset_out got=%b exp=0", btn_out); end
    total++; if (btn_rise !== '0) begin bad++; $display("FAIL reset_rise got=%b exp=0", btn_rise); end
    total++; if (btn_fall !== '0) begin bad++; $display("FAIL reset_fall got=%b exp=0", btn_fall); end
    total++; if (btn_long !== '0) begin bad++; $display("FAIL reset_long got=%b exp=0", btn_long); end
    rst_n = 1'b1;
    repeat (3) tick();
    total++;
    if ((btn_out | btn_rise | btn_fall | btn_long) !== '0) begin
      bad++; $display("FAIL reset_release got=%b exp=0", btn_out | btn_rise | btn_fall | btn_long);
    end
  endtask

  task automatic test_latency();
    int n;
    btn_in = 4'b0001;
    n = 0;
    while (btn_out[0] !== 1'b1 && n < 60) begin tick(); n++; end
    total++; if (n != LAT) begin bad++; $display("FAIL rise_latency got=%0d exp=%0d", n, LAT); end
    total++; if (btn_rise !== 4'b0001) begin bad++; $display("FAIL rise_pulse got=%b exp=0001", btn_rise); end
    total++; if (btn_out[3:1] !== 3'b000) begin bad++; $display("FAIL rise_others got=%b exp=000", btn_out[3:1]); end
    tick();
    total++; if (btn_rise !== '0) begin bad++; $display("FAIL rise_one_cycle got=%b exp=0", btn_rise); end
    repeat (5) tick();
    btn_in = '0;
    n = 0;
    while (btn_out[0] !== 1'b0 && n < 60) begin tick(); n++; end
    total++; if (n != LAT) begin bad++; $display("FAIL fall_latency got=%0d exp=%0d", n, LAT); end
    total++; if (btn_fall !== 4'b0001) begin bad++; $display("FAIL fall_pulse got=%b exp=0001", btn_fall); end
  endtask

  task automatic test_bounce();
    int rises, toggles;
    logic prev;
    do_reset();
    rises = 0; toggles = 0; prev = btn_out[1];
    for (int c = 0; c < 140; c++) begin
      btn_in[1] = (c >= 100) ? 1'b1 : (((c / 3) % 2) == 0);
      tick();
      if (btn_rise[1]) rises++;
      if (btn_out[1] !== prev) toggles++;
      prev = btn_out[1];
    end
    total++; if (rises != 1)      begin bad++; $display("FAIL bounce_rises got=%0d exp=1", rises); end
    total++; if (toggles != 1)    begin bad++; $display("FAIL bounce_toggles got=%0d exp=1", toggles); end
    total++; if (btn_out[1] !== 1'b1) begin bad++; $display("FAIL bounce_final got=%b exp=1", btn_out[1]); end
  endtask

  task automatic test_glitch();
    int falls, lows;
    btn_in[2] = 1'b1;
    repeat (30) tick();
    total++; if (btn_out[2] !== 1'b1) begin bad++; $display("FAIL glitch_sat got=%b exp=1", btn_out[2]); end
    falls = 0; lows = 0;
    btn_in[2] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == 10) btn_in[2] = 1'b1;
      tick();
      if (btn_fall[2])         falls++;
      if (btn_out[2] !== 1'b1) lows++;
    end
    total++; if (falls != 0) begin bad++; $display("FAIL glitch_fall got=%0d exp=0", falls); end
    total++; if (lows != 0)  begin bad++; $display("FAIL glitch_level got=%0d exp=0", lows); end
  endtask

  task automatic test_long_press();
    int rise_c, long_c, longs, falls, rises, both;
    do_reset();
    rise_c = -1; long_c = -1; longs = 0; falls = 0; both = 0;
    btn_in[3] = 1'b1;
    for (int c = 0; c < 260; c++) begin
      if (c == 200) btn_in[3] = 1'b0;
      tick();
      if (btn_rise[3]) rise_c = c;
      if (btn_long[3]) begin longs++; long_c = c; end
      if (btn_fall[3]) falls++;
      if (btn_long[3] && btn_fall[3]) both++;
    end
    total++; if (longs != 1) begin bad++; $display("FAIL long_count got=%0d exp=1", longs); end
    total++; if (long_c - rise_c != int'(LONG)) begin
      bad++; $display("FAIL long_delay got=%0d exp=%0d", long_c - rise_c, LONG);
    end
    total++; if (falls != 1) begin bad++; $display("FAIL long_release got=%0d exp=1", falls); end
    total++; if (both != 0)  begin bad++; $display("FAIL long_and_fall got=%0d exp=0", both); end
    longs = 0; rises = 0; falls = 0;
    btn_in[3] = 1'b1;
    for (int c = 0; c < 90; c++) begin
      if (c == 30) btn_in[3] = 1'b0;
      tick();
      if (btn_long[3]) longs++;
      if (btn_rise[3]) rises++;
      if (btn_fall[3]) falls++;
    end
    total++; if (longs != 0) begin bad++; $display("FAIL short_press_long got=%0d exp=0", longs); end
    total++; if (rises != 1 || falls != 1) begin
      bad++; $display("FAIL short_press_edges got=%0d/%0d exp=1/1", rises, falls);
    end
  endtask

  task automatic test_reset_mid_press();
    int n, early;
    do_reset();
    btn_in = 4'b0010;
    repeat (25) tick();
    btn_in = 4'b0011;
    repeat (SYNC + 8) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (btn_out !== '0) begin bad++; $display("FAIL midrst_out got=%b exp=0", btn_out); end
    total++; if ((btn_rise | btn_fall | btn_long) !== '0) begin
      bad++; $display("FAIL midrst_pulse got=%b exp=0", btn_rise | btn_fall | btn_long);
    end
    tick();
    rst_n = 1'b1;
    n = 0; early = 0;
    while (btn_rise[0] !== 1'b1 && n < 60) begin
      tick(); n++;
      if (btn_rise[0] !== 1'b1 && (btn_rise | btn_fall | btn_long) !== '0) early++;
    end
    total++; if (n != LAT) begin bad++; $display("FAIL midrst_latency got=%0d exp=%0d", n, LAT); end
    total++; if (btn_rise !== 4'b0011) begin bad++; $display("FAIL midrst_fresh got=%b exp=0011", btn_rise); end
    total++; if (early != 0) begin bad++; $display("FAIL midrst_early got=%0d exp=0", early); end
  endtask

  task automatic test_random_channels();
    int unsigned odds [N_CH];
    int overlap;
    odds[0] = 2; odds[1] = 9; odds[2] = 40; odds[3] = 150;
    do_reset();
    overlap = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < int'(N_CH); ch++)
        if ($urandom_range(odds[ch] - 1) == 0) btn_in[ch] = ~btn_in[ch];
      tick();
      total++; if (btn_out  !== m_out)  begin bad++; $display("FAIL rnd_out c=%0d got=%b exp=%b", c, btn_out, m_out); end
      total++; if (btn_rise !== m_rise) begin bad++; $display("FAIL rnd_rise c=%0d got=%b exp=%b", c, btn_rise, m_rise); end
      total++; if (btn_fall !== m_fall) begin bad++; $display("FAIL rnd_fall c=%0d got=%b exp=%b", c, btn_fall, m_fall); end
      total++; if (btn_long !== m_long) begin bad++; $display("FAIL rnd_long c=%0d got=%b exp=%b", c, btn_long, m_long); end
      if ((btn_long & btn_fall) !== '0) overlap++;
    end
    total++; if (overlap != 0) begin bad++; $display("FAIL rnd_long_fall got=%0d exp=0", overlap); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_bounce();
    test_glitch();
    test_long_press();
    test_reset_mid_press();
    test_random_channels();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
